// File: rtl/llc_rsp_out_buf_pkg.sv
// Shared cache constants, coherence response encodings and the packed
// response-buffer entry type.
package llc_rsp_out_buf_pkg;

  localparam int unsigned COH_MSG_TYPE_WIDTH = 2;
  localparam int unsigned LINE_ADDR_BITS     = 26;
  localparam int unsigned BITS_PER_LINE      = 128;
  localparam int unsigned INVACK_CNT_WIDTH   = 4;
  localparam int unsigned CACHE_ID_WIDTH     = 2;
  localparam int unsigned WORD_BITS          = 2;

  localparam logic [COH_MSG_TYPE_WIDTH-1:0] RSP_DATA     = COH_MSG_TYPE_WIDTH'(0);
  localparam logic [COH_MSG_TYPE_WIDTH-1:0] RSP_EDATA    = COH_MSG_TYPE_WIDTH'(1);
  localparam logic [COH_MSG_TYPE_WIDTH-1:0] RSP_INV_ACK  = COH_MSG_TYPE_WIDTH'(2);
  localparam logic [COH_MSG_TYPE_WIDTH-1:0] RSP_DATA_DMA = COH_MSG_TYPE_WIDTH'(3);

  typedef struct packed {
    logic [COH_MSG_TYPE_WIDTH-1:0] coh_msg;
    logic [LINE_ADDR_BITS-1:0]     addr;
    logic [BITS_PER_LINE-1:0]      line;
    logic [INVACK_CNT_WIDTH-1:0]   invack_cnt;
    logic [CACHE_ID_WIDTH-1:0]     req_id;
    logic [CACHE_ID_WIDTH-1:0]     dest_id;
    logic [WORD_BITS-1:0]          word_offset;
  } llc_rsp_out_entry_t;

endpackage

// File: rtl/llc_rsp_out_buf_if.sv
// Valid/ready response channel between the LLC core, the buffer and the NoC.
interface llc_rsp_out_buf_if;
  import llc_rsp_out_buf_pkg::*;

  logic                          valid;
  logic                          ready;
  logic [COH_MSG_TYPE_WIDTH-1:0] coh_msg;
  logic [LINE_ADDR_BITS-1:0]     addr;
  logic [BITS_PER_LINE-1:0]      line;
  logic [INVACK_CNT_WIDTH-1:0]   invack_cnt;
  logic [CACHE_ID_WIDTH-1:0]     req_id;
  logic [CACHE_ID_WIDTH-1:0]     dest_id;
  logic [WORD_BITS-1:0]          word_offset;

  modport master (
    output valid, coh_msg, addr, line, invack_cnt, req_id, dest_id, word_offset,
    input  ready
  );

  modport slave (
    input  valid, coh_msg, addr, line, invack_cnt, req_id, dest_id, word_offset,
    output ready
  );

endinterface

// File: rtl/llc_rsp_out_buf_mem.sv
// DEPTH-entry register array: one synchronous write port, one asynchronous
// read port. Storage is intentionally not reset.
module llc_rsp_out_buf_mem
  import llc_rsp_out_buf_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  llc_rsp_out_entry_t wdata,
  input  logic [AW-1:0]      raddr,
  output llc_rsp_out_entry_t rdata
);

  llc_rsp_out_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/llc_rsp_out_buf.sv
// LLC response output FIFO towards the NoC. Optional same-cycle bypass on an
// empty buffer is compiled in with LLC_RSP_OUT_BUF_BYPASS_EN.
module llc_rsp_out_buf
  import llc_rsp_out_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  llc_rsp_out_buf_if.slave        in_if,
  llc_rsp_out_buf_if.master       out_if,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]      wptr_q;
  logic [AW-1:0]      rptr_q;
  logic [CW-1:0]      count_q;
  llc_rsp_out_entry_t in_entry;
  llc_rsp_out_entry_t head_entry;
  llc_rsp_out_entry_t out_entry;
  logic               empty;
  logic               bypass;
  logic               push;
  logic               store;
  logic               deq;

  assign in_entry = '{
    coh_msg:     in_if.coh_msg,
    addr:        in_if.addr,
    line:        in_if.line,
    invack_cnt:  in_if.invack_cnt,
    req_id:      in_if.req_id,
    dest_id:     in_if.dest_id,
    word_offset: in_if.word_offset
  };

  assign empty       = (count_q == '0);
  assign in_if.ready = (count_q < CW'(DEPTH));

`ifdef LLC_RSP_OUT_BUF_BYPASS_EN
  assign bypass = empty & in_if.valid;
`else
  assign bypass = 1'b0;
`endif

  assign out_if.valid = ~empty | bypass;
  assign push         = in_if.valid & in_if.ready;
  // A bypassed beat taken by the NoC in the same cycle never enters storage
  assign store        = push & ~(bypass & out_if.ready);
  assign deq          = out_if.ready & ~empty;

  llc_rsp_out_buf_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (store & ~rst),
    .waddr (wptr_q),
    .wdata (in_entry),
    .raddr (rptr_q),
    .rdata (head_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (store) wptr_q <= wptr_q + AW'(1);
      if (deq)   rptr_q <= rptr_q + AW'(1);
      case ({store, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head entry when occupied, bypassed input when enabled, zero otherwise
  always_comb begin
    out_entry = '0;
    if (!empty)      out_entry = head_entry;
    else if (bypass) out_entry = in_entry;
  end

  assign out_if.coh_msg     = out_entry.coh_msg;
  assign out_if.addr        = out_entry.addr;
  assign out_if.line        = out_entry.line;
  assign out_if.invack_cnt  = out_entry.invack_cnt;
  assign out_if.req_id      = out_entry.req_id;
  assign out_if.dest_id     = out_entry.dest_id;
  assign out_if.word_offset = out_entry.word_offset;

  assign count = count_q;

endmodule

// File: tb/tb_llc_rsp_out_buf.sv
// Randomized self-checking bench for llc_rsp_out_buf against a queue model.
module tb_llc_rsp_out_buf;
  import llc_rsp_out_buf_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef LLC_RSP_OUT_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [$clog2(DEPTH):0] count;

  llc_rsp_out_buf_if in_if ();
  llc_rsp_out_buf_if out_if ();

  llc_rsp_out_buf #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .in_if  (in_if),
    .out_if (out_if),
    .count  (count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  llc_rsp_out_entry_t model_q[$];

  task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic llc_rsp_out_entry_t rand_entry();
    llc_rsp_out_entry_t e;
    e.coh_msg     = COH_MSG_TYPE_WIDTH'($urandom);
    e.addr        = LINE_ADDR_BITS'($urandom);
    e.line        = {$urandom, $urandom, $urandom, $urandom};
    e.invack_cnt  = INVACK_CNT_WIDTH'($urandom);
    e.req_id      = CACHE_ID_WIDTH'($urandom);
    e.dest_id     = CACHE_ID_WIDTH'($urandom);
    e.word_offset = WORD_BITS'($urandom);
    return e;
  endfunction

  // One clock: drive, check visible outputs at negedge, then advance the model.
  task automatic cycle(input logic iv, input llc_rsp_out_entry_t e, input logic ordy, input logic r);
    int                 size;
    logic               byp;
    logic               exp_valid;
    llc_rsp_out_entry_t exp_e;
    llc_rsp_out_entry_t got_e;
    rst                = r;
    in_if.valid        = iv;
    in_if.coh_msg      = e.coh_msg;
    in_if.addr         = e.addr;
    in_if.line         = e.line;
    in_if.invack_cnt   = e.invack_cnt;
    in_if.req_id       = e.req_id;
    in_if.dest_id      = e.dest_id;
    in_if.word_offset  = e.word_offset;
    out_if.ready       = ordy;
    @(negedge clk);
    size      = model_q.size();
    byp       = BYP && size == 0 && iv;
    exp_valid = (size != 0) || byp;
    exp_e     = (size != 0) ? model_q[0] : (byp ? e : '0);
    got_e     = '{coh_msg: out_if.coh_msg, addr: out_if.addr, line: out_if.line,
                  invack_cnt: out_if.invack_cnt, req_id: out_if.req_id,
                  dest_id: out_if.dest_id, word_offset: out_if.word_offset};
    check_val("out_valid", 192'(out_if.valid), 192'(exp_valid));
    check_val("in_ready", 192'(in_if.ready), 192'(size < DEPTH));
    check_val("count", 192'(count), 192'(size));
    check_val("out_fields", 192'(got_e), 192'(exp_e));
    @(posedge clk);
    if (r) begin
      model_q.delete();
    end else if (byp && ordy) begin
      // consumed straight through, nothing stored
    end else begin
      if (size != 0 && ordy) void'(model_q.pop_front());
      if (iv && size < DEPTH) model_q.push_back(e);
    end
    #1;
  endtask

  llc_rsp_out_entry_t e0;
  llc_rsp_out_entry_t idle_e;

  initial begin
    idle_e = '0;
    rst = 1'b1;
    in_if.valid = 1'b0;
    in_if.coh_msg = '0; in_if.addr = '0; in_if.line = '0; in_if.invack_cnt = '0;
    in_if.req_id = '0; in_if.dest_id = '0; in_if.word_offset = '0;
    out_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, then single entry with out_ready high
    cycle(1'b0, idle_e, 1'b0, 1'b0);
    e0 = rand_entry();
    e0.coh_msg = RSP_DATA; e0.addr = LINE_ADDR_BITS'(26'h1A2B); e0.dest_id = CACHE_ID_WIDTH'(3);
    cycle(1'b1, e0, 1'b1, 1'b0);
    cycle(1'b0, idle_e, 1'b1, 1'b0);
    cycle(1'b0, idle_e, 1'b1, 1'b0);

    // fill to full under stall, 5th push ignored, drain in order
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, rand_entry(), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, idle_e, 1'b1, 1'b0);

    // full with push+pop: only pop; at 2 push+pop keeps count
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_entry(), 1'b0, 1'b0);
    cycle(1'b1, rand_entry(), 1'b1, 1'b0);
    cycle(1'b0, idle_e, 1'b1, 1'b0);
    cycle(1'b1, rand_entry(), 1'b1, 1'b0);
    cycle(1'b1, rand_entry(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, idle_e, 1'b1, 1'b0);

    // reset with 3 entries and a simultaneous push
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_entry(), 1'b0, 1'b0);
    cycle(1'b1, rand_entry(), 1'b0, 1'b1);
    cycle(1'b0, idle_e, 1'b1, 1'b0);

    // empty buffer push with out_ready: latency 1, or same cycle with bypass
    cycle(1'b1, rand_entry(), 1'b1, 1'b0);
    cycle(1'b0, idle_e, 1'b1, 1'b0);
    cycle(1'b1, rand_entry(), 1'b0, 1'b0);
    cycle(1'b0, idle_e, 1'b1, 1'b0);
    cycle(1'b0, idle_e, 1'b0, 1'b0);

    // stream 20 entries with random stalls across pointer wrap
    begin
      int sent = 0;
      int budget = 0;
      while ((sent < 20 || model_q.size() != 0) && budget < 500) begin
        logic iv;
        logic acc;
        iv  = (sent < 20) && ($urandom_range(0, 3) != 0);
        acc = iv && (model_q.size() < DEPTH);
        cycle(iv, rand_entry(), logic'($urandom_range(0, 2) != 0), 1'b0);
        if (acc) sent++;
        budget++;
      end
      check_val("stream_done", 192'(budget < 500), 192'(1));
    end

    // free-running random traffic
    for (int i = 0; i < 200; i++)
      cycle(logic'($urandom_range(0, 1)), rand_entry(), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 49) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/llc_rsp_out_buf.md
LLC_RSP_OUT_BUF -- requirements
Module: llc_rsp_out_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving FIFO entry count (power of two, 2..16).
REQ-002 Clock and reset SHALL be one clock and one reset, with reset synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  LLC core presents a response.
REQ-006 in_ready  output  1  buffer can accept; transfer when in_valid and in_ready are high at a rising edge.
REQ-007 in_coh_msg  input  COH_MSG_TYPE_WIDTH  data, e-data, inv-ack or rsp-data-dma.
REQ-008 in_addr  input  LINE_ADDR_BITS  line address.
REQ-009 in_line  input  BITS_PER_LINE  line payload.
REQ-010 in_invack_cnt  input  INVACK_CNT_WIDTH  inv-ack count, or last-line marker for DMA.
REQ-011 in_req_id, in_dest_id  input  CACHE_ID_WIDTH each  requester id and destination id.
REQ-012 in_word_offset  input  WORD_BITS  word offset.
REQ-013 out_valid, out_ready, out_<field>  out_valid is an output (1); out_ready is an input (1); out_<field> are outputs mirroring REQ-007..012, carrying the head entry to the NoC.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 The buffer SHALL be a FIFO that preserves in-order delivery and keeps all fields of one response bundled in one entry.
REQ-016 in_ready SHALL equal (count < DEPTH); it SHALL NOT depend on out_ready.
REQ-017 out_valid SHALL equal (count != 0), and out_<field> SHALL show the head entry whenever out_valid is high.
REQ-018 Once asserted, out_valid and out_<field> SHALL hold stable until out_ready is sampled high.
REQ-019 Write and read pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH without a special case.
REQ-020 Count update per edge: push only -> +1; pop only -> -1; push and pop together -> unchanged.
REQ-021 When full, a simultaneous pop SHALL NOT permit a push in the same cycle (per REQ-016).
REQ-022 When empty, a push SHALL appear on the output after 1 cycle (latency 1), unless the feature in REQ-026 is compiled in.
REQ-023 in_valid while in_ready is low SHALL be ignored, with no state change.
REQ-024 When empty, out_<field> SHALL drive zero.

Reset
REQ-025 On rst high at a rising edge: pointers = 0, count = 0, out_valid = 0, in_ready = 1 (from the next cycle).
- Entry storage SHALL NOT require reset.
- Reset mid-transfer SHALL discard all entries; a push in the same cycle as rst SHALL be dropped.

Configuration
REQ-026 Macro LLC_RSP_OUT_BUF_BYPASS_EN defined: when count = 0 and in_valid is high, out_valid SHALL assert in the same cycle and out_<field> SHALL show the in_<field> values combinationally.
- If out_ready is also high, the entry SHALL NOT be stored and count SHALL stay 0.
- Macro undefined: no combinational in->out path exists; behaviour is exactly REQ-022.

Structure
REQ-027 Message-type, address, line, invack, cache-id and word-offset widths SHALL come from the shared cache constants/types package, together with the coh_msg encodings.
- No new shared typedefs are required beyond a packed entry type, llc_rsp_out_entry_t, added to that package.
REQ-028 Storage SHALL be one sub-module, llc_rsp_out_buf_mem: a DEPTH x entry-width register array with one write port and one asynchronous read port.

Verification
REQ-029 Reset, then push one entry {coh_msg=data, addr=0x1A2B, dest_id=3} with out_ready=1 -> out_valid high the next cycle with matching fields; count goes 1 then 0.
REQ-030 Hold out_ready=0 and push 4 entries (DEPTH=4) -> in_ready=0 and count=4; a 5th in_valid is ignored; then out_ready=1 drains 4 entries in push order.
REQ-031 At full, assert a push and a pop together -> only the pop completes and count becomes 3; at count=2, a simultaneous push and pop -> count stays 2.
REQ-032 Stream 20 entries with random out_ready stalls -> ordering is correct across pointer wrap-around, and output fields stay stable while stalled.
REQ-033 Assert rst with count=3 -> count=0 and out_valid=0 the next cycle; a push asserted together with rst is not stored.
REQ-034 With LLC_RSP_OUT_BUF_BYPASS_EN, empty buffer, in_valid=1 and out_ready=1 -> same-cycle output and count stays 0; without the macro -> 1-cycle latency.
